// File: rtl/bsg_async_fifo_pkg.sv
// Shared helpers for the async FIFO pointer controllers (write and read side).
package bsg_async_fifo_pkg;

  // Pointers carry one extra MSB beyond the address so full and empty can be told apart.
  function automatic int ptr_width(input int lg_size);
    return lg_size + 1;
  endfunction

  // Prefix-XOR gray decode; callers zero-extend and cast the result to their pointer width.
  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin = gray;
    for (int s = 1; s < 32; s = s * 2) begin
      bin = bin ^ (bin >> s);
    end
    return bin;
  endfunction

endpackage

// File: rtl/bsg_binary_plus_one_to_gray.sv
// Combinational increment-then-gray-encode used to preload the next gray pointer.
module bsg_binary_plus_one_to_gray #(
  parameter int width_p = 4
) (
  input  logic [width_p-1:0] binary_i,
  output logic [width_p-1:0] gray_o
);

  logic [width_p-1:0] plus_one;

  always_comb begin
    plus_one = binary_i + width_p'(1);
    gray_o   = plus_one ^ (plus_one >> 1);
  end

endmodule

// File: rtl/bsg_sync_gray_ptr.sv
// Multi-flop synchronizer for a gray-coded pointer crossing into the local clock domain.
module bsg_sync_gray_ptr #(
  parameter int width_p  = 4,
  parameter int stages_p = 2
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [width_p-1:0] gray_i,
  output logic [width_p-1:0] gray_o
);

  logic [width_p-1:0] chain [stages_p];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < stages_p; i++) begin
        chain[i] <= '0;
      end
    end else begin
      chain[0] <= gray_i;
      for (int i = 1; i < stages_p; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  assign gray_o = chain[stages_p-1];

endmodule

// File: rtl/bsg_async_fifo_wr_ctrl.sv
// Write-side pointer controller for an async FIFO: binary/gray write pointers,
// synchronized read pointer, full/ready flags and occupancy estimate.
module bsg_async_fifo_wr_ctrl
  import bsg_async_fifo_pkg::*;
#(
  parameter int lg_size_p     = 3,
  parameter int sync_stages_p = 2
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 v_i,
  output logic                 ready_o,
  output logic                 w_v_o,
  output logic [lg_size_p-1:0] w_addr_o,
  output logic [lg_size_p:0]   w_ptr_gray_o,
  input  logic [lg_size_p:0]   r_ptr_gray_i,
  output logic                 full_o,
  output logic [lg_size_p:0]   count_o
);

  localparam int ptr_w = ptr_width(lg_size_p);

  // Full when the writer is exactly one lap ahead: in gray, the top two bits differ.
  localparam logic [ptr_w-1:0] full_mask = ptr_w'(3) << (ptr_w - 2);

  logic [ptr_w-1:0] bin_r;
  logic [ptr_w-1:0] gray_r;
  logic [ptr_w-1:0] gray_next;
  logic [ptr_w-1:0] rs_gray;
  logic [ptr_w-1:0] rs_bin;
  logic             full;
  logic             accept;

  bsg_binary_plus_one_to_gray #(
    .width_p(ptr_w)
  ) inc_to_gray (
    .binary_i(bin_r),
    .gray_o  (gray_next)
  );

  bsg_sync_gray_ptr #(
    .width_p (ptr_w),
    .stages_p(sync_stages_p)
  ) rd_ptr_sync (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .gray_i   (r_ptr_gray_i),
    .gray_o   (rs_gray)
  );

  always_comb begin
    rs_bin = ptr_w'(gray2bin(32'(rs_gray)));
    full   = (gray_r == (rs_gray ^ full_mask));
    accept = v_i & ~full;
  end

  // Gray register loads a precomputed value so it never passes through intermediate codes.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      bin_r  <= '0;
      gray_r <= '0;
    end else if (accept) begin
      bin_r  <= bin_r + ptr_w'(1);
      gray_r <= gray_next;
    end
  end

  assign full_o       = full;
  assign ready_o      = ~full;
  assign w_v_o        = accept;
  assign w_addr_o     = bin_r[lg_size_p-1:0];
  assign w_ptr_gray_o = gray_r;
  assign count_o      = bin_r - rs_bin;

endmodule

// File: tb/tb_bsg_async_fifo_wr_ctrl.sv
// Self-checking bench for bsg_async_fifo_wr_ctrl (lg_size_p=2, sync_stages_p=2).
module tb_bsg_async_fifo_wr_ctrl;

  localparam int LG    = 2;
  localparam int ST    = 2;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       v = 1'b0;
  logic [2:0] r_ptr_gray = 3'b000;
  logic       ready, w_v, full;
  logic [1:0] w_addr;
  logic [2:0] w_ptr_gray, count;

  int tests = 0;
  int fails = 0;

  // Reference model: total words written, total words read, and the reader's
  // count history as seen through the synchronizer delay.
  int wr_cnt = 0;
  int rd_cnt = 0;
  int hq[$];
  logic [2:0] prev_gray = 3'b000;

  bsg_async_fifo_wr_ctrl #(
    .lg_size_p    (LG),
    .sync_stages_p(ST)
  ) dut (
    .clk_i       (clk),
    .reset_n_i   (reset_n),
    .v_i         (v),
    .ready_o     (ready),
    .w_v_o       (w_v),
    .w_addr_o    (w_addr),
    .w_ptr_gray_o(w_ptr_gray),
    .r_ptr_gray_i(r_ptr_gray),
    .full_o      (full),
    .count_o     (count)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] toGray(input int n);
    logic [2:0] b;
    b = 3'(n % 8);
    return b ^ (b >> 1);
  endfunction

  function automatic int modelOcc();
    return wr_cnt - hq[0];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic checkAll(input string tag);
    int occ;
    logic hd_ok, inv_ok;
    occ = modelOcc();
    checkOutput({tag, ":gray"},  32'(w_ptr_gray), 32'(toGray(wr_cnt)));
    checkOutput({tag, ":addr"},  32'(w_addr), 32'(wr_cnt % DEPTH));
    checkOutput({tag, ":full"},  32'(full), 32'(occ == DEPTH));
    checkOutput({tag, ":ready"}, 32'(ready), 32'(occ != DEPTH));
    checkOutput({tag, ":count"}, 32'(count), 32'(occ));
    checkOutput({tag, ":w_v"},   32'(w_v), 32'(v && (occ != DEPTH)));
    hd_ok  = ($countones(w_ptr_gray ^ prev_gray) <= 1);
    inv_ok = (count <= 3'd4) && (full == (count == 3'd4));
    checkOutput({tag, ":hamming"}, 32'(hd_ok), 32'd1);
    checkOutput({tag, ":inv"},     32'(inv_ok), 32'd1);
    prev_gray = w_ptr_gray;
  endtask

  // Called at a negedge: drive, check, take one rising edge, end on the next negedge.
  task automatic applyStimulus(input logic vv, input int rd, input string tag);
    v          = vv;
    rd_cnt     = rd;
    r_ptr_gray = toGray(rd);
    #1;
    checkAll(tag);
    @(posedge clk);
    if (vv && modelOcc() < DEPTH) wr_cnt++;
    hq.push_back(rd_cnt);
    void'(hq.pop_front());
    @(negedge clk);
  endtask

  task automatic doReset(input string tag);
    reset_n    = 1'b0;
    rd_cnt     = 0;
    r_ptr_gray = 3'b000;
    #1;
    checkOutput({tag, ":gray"},  32'(w_ptr_gray), 32'd0);
    checkOutput({tag, ":addr"},  32'(w_addr), 32'd0);
    checkOutput({tag, ":full"},  32'(full), 32'd0);
    checkOutput({tag, ":ready"}, 32'(ready), 32'd1);
    checkOutput({tag, ":count"}, 32'(count), 32'd0);
    checkOutput({tag, ":w_v"},   32'(w_v), 32'(v));
    wr_cnt = 0;
    hq = '{0, 0};
    prev_gray = 3'b000;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [2:0] wrap_seq [9];
    int rd_next;
    wrap_seq = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000, 3'b001};
    hq = '{0, 0};

    @(negedge clk);
    doReset("rst0");

    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 0, "fill");
    #1;
    checkOutput("fill:full_end", 32'(full), 32'd1);
    checkOutput("fill:count_end", 32'(count), 32'd4);
    checkOutput("fill:gray_end", 32'(w_ptr_gray), 32'b110);

    applyStimulus(1'b0, 1, "drain0");
    #1;
    checkOutput("drain:full_1edge", 32'(full), 32'd1);
    applyStimulus(1'b0, 1, "drain1");
    #1;
    checkOutput("drain:full_2edge", 32'(full), 32'd0);
    checkOutput("drain:ready_2edge", 32'(ready), 32'd1);
    checkOutput("drain:count_2edge", 32'(count), 32'd3);
    applyStimulus(1'b1, 1, "drain_wr");
    #1;
    checkOutput("drain:gray_111", 32'(w_ptr_gray), 32'b111);
    checkOutput("drain:full_again", 32'(full), 32'd1);

    applyStimulus(1'b1, 2, "simul0");
    applyStimulus(1'b1, 2, "simul1");
    applyStimulus(1'b1, 2, "simul2");
    #1;
    checkOutput("simul:gray_after", 32'(w_ptr_gray), 32'b101);
    checkOutput("simul:addr_after", 32'(w_addr), 32'd2);

    @(negedge clk);
    doReset("rst_wrap");
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, wr_cnt, "wrap");
      #1;
      checkOutput("wrap:seq", 32'(w_ptr_gray), 32'(wrap_seq[i]));
      checkOutput("wrap:nofull", 32'(full), 32'd0);
    end

    @(negedge clk);
    doReset("rst_pre");
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, wr_cnt, "pre5");
    v = 1'b1;
    doReset("rst_mid");

    for (int c = 0; c < 10000; c++) begin
      rd_next = rd_cnt;
      if (rd_cnt < wr_cnt && $urandom_range(0, 2) == 0) rd_next = rd_cnt + 1;
      applyStimulus(($urandom_range(0, 3) != 0), rd_next, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bsg_async_fifo_wr_ctrl.md
Name: bsg_async_fifo_wr_ctrl

Overview:
- Write-side pointer controller for an async FIFO.
- Holds the registered binary and gray write pointers, advancing them by one on each accepted write. The next gray value comes from the existing bsg_binary_plus_one_to_gray datapath, so the gray register loads glitch-free.
- Synchronizes the read-domain gray pointer into clk_i, generates full/ready and an occupancy estimate, and drives the storage write enable and address.

Parameters:
- lg_size_p, 3, log2 of FIFO depth. Depth = 2^lg_size_p. Pointers are lg_size_p+1 bits wide.
- sync_stages_p, 2, number of flops in the read-pointer synchronizer. Legal range is 2..3.

Ports:
- clk_i  in  1  write-domain clock.
- reset_n_i  in  1  reset, asynchronous assert, active-low.
- v_i  in  1  write request.
- ready_o  out  1  write accepted this cycle if v_i is high. Equals ~full_o.
- w_v_o  out  1  storage write enable = v_i & ready_o.
- w_addr_o  out  lg_size_p  storage write address = low bits of the binary write pointer.
- w_ptr_gray_o  out  lg_size_p+1  registered gray write pointer, sent to the read domain.
- r_ptr_gray_i  in  lg_size_p+1  gray read pointer from the read domain, asynchronous to clk_i.
- full_o  out  1  FIFO full (conservative).
- count_o  out  lg_size_p+1  occupancy estimate, range 0..2^lg_size_p.

Behaviour:
- Reset (reset_n_i low, takes effect immediately, no clock needed):
  - binary pointer, gray pointer and all synchronizer flops = 0.
  - w_ptr_gray_o=0, w_addr_o=0, full_o=0, ready_o=1, count_o=0, w_v_o=v_i.
- Reset release: the first accept can occur on the first rising edge after release. Release is assumed synchronized externally.
- Accept:
  - The write is accepted when v_i & ~full_o is sampled at a rising clk_i edge.
  - On that edge: bin <= bin+1 (mod 2^(lg_size_p+1)), and gray <= bsg_binary_plus_one_to_gray(bin).
  - The new address and gray pointer are visible one cycle after accept.
- v_i while full: ignored. No pointer change and w_v_o=0. There is no error flag.
- v_i=0: pointers hold.
- Synchronizer: r_ptr_gray_i passes through sync_stages_p flops to give rs_gray. A change on r_ptr_gray_i reaches rs_gray after exactly sync_stages_p edges.
- full_o:
  - Combinational from flops only: full_o = (gray == {~rs_gray[top:top-1], rs_gray[top-2:0]}).
  - No dependency on any input, so it is glitch-free relative to clk_i.
- count_o:
  - count_o = bin - gray2bin(rs_gray), mod 2^(lg_size_p+1). It is derived from flops only.
  - It equals 2^lg_size_p exactly when full_o=1.
- Wrap-around:
  - The binary pointer wraps from all-ones to 0, and the gray pointer wraps from 10..0 to 0..0.
  - The address wraps from 2^lg_size_p-1 to 0.
  - full_o/count_o stay correct across wrap because of the extra MSB.
- Simultaneous events:
  - A read-pointer change on the same cycle as a blocked write does not unblock that cycle.
  - It unblocks sync_stages_p cycles later.
- Reset mid-operation: all state clears at once and any in-flight accept is dropped.
- Invariants:
  - w_ptr_gray_o changes in at most one bit per clk_i edge.
  - w_ptr_gray_o always equals the gray encoding of bin.

Decomposition:
- Shared package bsg_async_fifo_pkg holds:
  - the gray2bin function, parameterized by width;
  - the ptr-width helper (lg_size_p+1).
- The bin+1 to gray conversion reuses bsg_binary_plus_one_to_gray, instantiated at width lg_size_p+1.
- One new sub-module is natural: bsg_sync_gray_ptr. It is a sync_stages_p-deep flop chain with async active-low reset and is reused by the read-side controller.

Test Plan (lg_size_p=2, sync_stages_p=2, 3-bit pointers):
1. Reset: assert reset_n_i low mid-run with bin=5 -> in the same cycle: w_ptr_gray_o=000, w_addr_o=0, full_o=0, ready_o=1, count_o=0.
2. Fill: r_ptr_gray_i=000, v_i high for 5 cycles.
   - w_addr_o steps 0,1,2,3; w_ptr_gray_o steps 001,011,010,110.
   - full_o=1 and count_o=4 after the 4th accept.
   - The 5th request gives w_v_o=0 and no pointer change.
3. Drain release: at full, set r_ptr_gray_i=001 -> full_o falls and ready_o rises exactly 2 edges later, with count_o=3. The next v_i is accepted at w_addr_o=0 and w_ptr_gray_o goes to 111.
4. Wrap: the reader tracks the writer, and 9 accepts are made from reset.
   - Gray sequence is 001,011,010,110,111,101,100,000,001.
   - w_addr_o wraps 3 to 0 twice.
   - full_o is never asserted.
5. Simultaneous: at full, raise v_i in the same cycle r_ptr_gray_i advances -> that cycle w_v_o=0; the accept occurs on the 2nd following edge.
6. Gray property: random v_i and random legal reader advance for 10k cycles.
   - Checker asserts that w_ptr_gray_o Hamming distance per edge is ≤1.
   - Checker asserts count_o ≤ 4 and full_o == (count_o==4).
